// File: rtl/aer_depacketizer.sv
// -----------------------------------------------------------------------------
// aer_depacketizer
//
// Receive end of the AER link. Address-events arrive over a 4-phase req/ack
// handshake. Each one is decoded into a channel ID or a frame marker, stamped
// with the local tick timestamp and queued in a show-ahead FIFO. The FIFO
// head is offered downstream as a valid/ready stream. While the FIFO is full,
// a legal event is not acknowledged, which holds off the link.
//
// Ports:
//   clk, rst_n   clock; asynchronous active-low reset
//   aer_req      link request (asynchronous, synchronised internally)
//   aer_addr     bundled address, stable while aer_req is high
//   aer_ack      link acknowledge
//   ts_tick      timestamp increment strobe
//   evt_valid    FIFO head valid
//   evt_ready    consumer ready
//   evt_ch       head channel ID (0 for frame markers)
//   evt_frame    head is a frame marker
//   evt_ts       head timestamp (0 when timestamping is compiled out)
//   fifo_level   FIFO occupancy
//   drop_cnt     saturating count of discarded out-of-range events
//
// Build option:
//   AER_DEPACK_TIMESTAMP_EN  when defined, the timestamp counter is built and
//                            each FIFO entry carries a TS_W-bit timestamp.
//                            When undefined, ts_tick is ignored and evt_ts
//                            is 0.
// -----------------------------------------------------------------------------
module aer_depacketizer #(
   parameter int ADDR_W = 8,
   parameter int NUM_CH = 64,
   parameter int CH_W   = 7,
   parameter int DEPTH  = 16,
   parameter int TS_W   = 12
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     aer_req,
   input  logic [ADDR_W-1:0]        aer_addr,
   output logic                     aer_ack,
   input  logic                     ts_tick,
   output logic                     evt_valid,
   input  logic                     evt_ready,
   output logic [CH_W-1:0]          evt_ch,
   output logic                     evt_frame,
   output logic [TS_W-1:0]          evt_ts,
   output logic [$clog2(DEPTH):0]   fifo_level,
   output logic [7:0]               drop_cnt
);

   localparam int AW = $clog2(DEPTH);
`ifdef AER_DEPACK_TIMESTAMP_EN
   localparam int ENTRY_W = 1 + CH_W + TS_W;
   localparam logic [TS_W-1:0] TS_ONE = {{(TS_W-1){1'b0}}, 1'b1};
`else
   localparam int ENTRY_W = 1 + CH_W;
`endif
   localparam logic [AW:0]   PTR_ONE  = {{AW{1'b0}}, 1'b1};
   localparam logic [AW:0]   DEPTH_L  = {1'b1, {AW{1'b0}}};
   localparam logic [CH_W:0] NUM_CH_L = (CH_W+1)'(NUM_CH);

   typedef enum logic {IDLE, ACK} state_t;

   // drop counter sticks at its maximum instead of wrapping
   function automatic logic [7:0] sat_inc8(input logic [7:0] c);
      if (c == 8'hFF) begin
         return c;
      end
      return c + 8'd1;
   endfunction

   logic                sync1_q, sync1_d;
   logic                req_s_q, req_s_d;
   state_t              state_q, state_d;
   logic                ack_q, ack_d;
   logic [AW:0]         wr_ptr_q, wr_ptr_d;
   logic [AW:0]         rd_ptr_q, rd_ptr_d;
   logic [7:0]          drop_cnt_q, drop_cnt_d;
`ifdef AER_DEPACK_TIMESTAMP_EN
   logic [TS_W-1:0]     ts_q, ts_d;
`endif

   logic [ENTRY_W-1:0]  mem_q [DEPTH];
   logic [ENTRY_W-1:0]  wr_entry;
   logic [ENTRY_W-1:0]  head;

   logic                addr_frame;
   logic [CH_W-1:0]     addr_ch;
   logic [CH_W-1:0]     dec_ch;
   logic                addr_legal;
   logic [AW:0]         level;
   logic                full;
   logic                empty;
   logic                push;
   logic                pop;

   // address decode; only consulted in IDLE with req_s high
   assign addr_frame = aer_addr[ADDR_W-1];
   assign addr_ch    = aer_addr[ADDR_W-2:0];
   assign addr_legal = addr_frame | ({1'b0, addr_ch} < NUM_CH_L);
   assign dec_ch     = addr_frame ? '0 : addr_ch;

   assign level = wr_ptr_q - rd_ptr_q;
   assign full  = (level == DEPTH_L);
   assign empty = (wr_ptr_q == rd_ptr_q);
   assign pop   = evt_ready & ~empty;

   always_comb begin
      sync1_d    = aer_req;
      req_s_d    = sync1_q;
      state_d    = state_q;
      ack_d      = ack_q;
      drop_cnt_d = drop_cnt_q;
      push       = 1'b0;

      case (state_q)
         IDLE: begin
            if (req_s_q) begin
               if (!addr_legal) begin
                  drop_cnt_d = sat_inc8(drop_cnt_q);
                  state_d    = ACK;
                  ack_d      = 1'b1;
               end else if (!full) begin
                  // a pop in this same cycle does not make room: full is
                  // judged on the registered pointers only
                  push    = 1'b1;
                  state_d = ACK;
                  ack_d   = 1'b1;
               end
            end
         end
         ACK: begin
            if (!req_s_q) begin
               state_d = IDLE;
               ack_d   = 1'b0;
            end
         end
         default: begin
            state_d = IDLE;
            ack_d   = 1'b0;
         end
      endcase

      wr_ptr_d = push ? wr_ptr_q + PTR_ONE : wr_ptr_q;
      rd_ptr_d = pop  ? rd_ptr_q + PTR_ONE : rd_ptr_q;

`ifdef AER_DEPACK_TIMESTAMP_EN
      // a pushed frame marker restarts the time base; it wins over a tick
      if (push && addr_frame) begin
         ts_d = '0;
      end else if (ts_tick) begin
         ts_d = ts_q + TS_ONE;
      end else begin
         ts_d = ts_q;
      end
`endif
   end

`ifdef AER_DEPACK_TIMESTAMP_EN
   assign wr_entry  = {addr_frame, dec_ch, ts_q};
   assign evt_ts    = head[TS_W-1:0];
   assign evt_ch    = head[TS_W +: CH_W];
   assign evt_frame = head[ENTRY_W-1];
`else
   logic unused_ts_tick;
   assign unused_ts_tick = ts_tick;
   assign wr_entry  = {addr_frame, dec_ch};
   assign evt_ts    = '0;
   assign evt_ch    = head[CH_W-1:0];
   assign evt_frame = head[ENTRY_W-1];
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync1_q    <= 1'b0;
         req_s_q    <= 1'b0;
         state_q    <= IDLE;
         ack_q      <= 1'b0;
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         drop_cnt_q <= '0;
`ifdef AER_DEPACK_TIMESTAMP_EN
         ts_q       <= '0;
`endif
      end else begin
         sync1_q    <= sync1_d;
         req_s_q    <= req_s_d;
         state_q    <= state_d;
         ack_q      <= ack_d;
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         drop_cnt_q <= drop_cnt_d;
`ifdef AER_DEPACK_TIMESTAMP_EN
         ts_q       <= ts_d;
`endif
      end
   end

   // FIFO storage carries data only, so it has no reset
   always_ff @(posedge clk) begin
      if (push) begin
         mem_q[wr_ptr_q[AW-1:0]] <= wr_entry;
      end
   end

   // show-ahead head
   assign head       = mem_q[rd_ptr_q[AW-1:0]];
   assign evt_valid  = ~empty;
   assign aer_ack    = ack_q;
   assign fifo_level = level;
   assign drop_cnt   = drop_cnt_q;

endmodule
